// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiplier block.
//   state_t  : control FSM states (IDLE, BUSY)
//   DATA_W   : operand / HI / LO width
//   PROD_W   : full product width
//   MULT_LAT_DEF : default accept-to-update latency in cycles
//   mag()    : operand magnitude for signed or unsigned mode
package mult_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned PROD_W       = 64;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned MULT_LAT_DEF = 4;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } state_t;

    // Two's-complement negation of 0x80000000 yields 0x80000000, which read
    // unsigned is exactly 2^31, so the most negative value needs no special case.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mult_32b.sv
// Combinational 32x32 unsigned multiplier.
//   a, b : unsigned operands
//   prod : full 64-bit unsigned product
module mult_32b
    import mult_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [PROD_W-1:0] prod
);

    assign prod = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult_hilo.sv
// Multi-cycle multiplier with HI/LO result registers.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : accept op_a * op_b (with is_signed) when idle
//   is_signed    : 1 = two's-complement operands, 0 = unsigned
//   op_a, op_b   : 32-bit operands
//   mthi, mtlo   : direct writes of wdata to hi / lo when idle
//   wdata        : data for direct writes
//   hi, lo       : registered upper / lower product halves
//   busy         : operation in flight
//   done         : one-cycle pulse following the HI/LO update
module mult_hilo
    import mult_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              done_q, done_d;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] result;

    mult_32b u_mult (
        .a    (a_q),
        .b    (b_q),
        .prod (prod)
    );

    // Sign fix-up on the unsigned product of the magnitudes.
    assign result = neg_q ? (PROD_W'(0) - prod) : prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Start takes priority; simultaneous direct writes are dropped.
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MULT_LAT - 1);
                    a_d     = mag(op_a, is_signed);
                    b_d     = mag(op_b, is_signed);
                    neg_d   = is_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    hi_d    = result[PROD_W-1:DATA_W];
                    lo_d    = result[DATA_W-1:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == BUSY);
    assign done = done_q;

endmodule

// File: doc/mult_hilo.md
MULT_HILO -- requirements
Module: mult_hilo

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, meaning cycles from operation accept to HI/LO update; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to multiply op_a by op_b.
REQ-005 SHALL have port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have ports op_a and op_b, input, 32 each, multiplicand and multiplier; sampled with start.
REQ-007 SHALL have ports mthi and mtlo, input, 1 each, direct-write strobes for HI and LO.
REQ-008 SHALL have port wdata, input, 32, data for mthi/mtlo.
REQ-009 SHALL have ports hi and lo, output, 32 each, registered upper and lower product halves.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-011 SHALL have port done, output, 1, single-cycle pulse after HI/LO update.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY plus a 4-bit down-counter.
REQ-013 IDLE with start=1 at edge k SHALL latch operands and is_signed, enter BUSY, load counter MULT_LAT-1; busy high from edge k.
REQ-014 BUSY SHALL decrement the counter each edge; at counter 0 (edge k+MULT_LAT) SHALL write HI/LO, return to IDLE, drop busy, and assert done for exactly the following cycle.
REQ-015 Unsigned mode: {hi,lo} SHALL equal the full 64-bit unsigned product, no truncation.
REQ-016 Signed mode: SHALL form operand magnitudes, multiply unsigned, and negate the 64-bit result when operand signs differ; 0x80000000 SHALL be handled as magnitude 2^31.
REQ-017 start while BUSY SHALL be ignored; the in-flight operation and its operands are unaffected.
REQ-018 mthi/mtlo in IDLE SHALL write wdata to hi/lo at that edge; both asserted SHALL write both.
REQ-019 mthi/mtlo while BUSY SHALL be ignored.
REQ-020 start together with mthi or mtlo in IDLE: start SHALL win; the direct writes are dropped.
REQ-021 start in the cycle done is high SHALL be accepted (back-to-back issue, FSM is IDLE).
REQ-022 hi/lo SHALL hold their previous values throughout BUSY until the write edge.

Reset
REQ-023 rst SHALL asynchronously force IDLE, counter 0, hi=0, lo=0, busy=0, done=0, latched operands 0.
REQ-024 rst mid-operation SHALL abandon the operation; no HI/LO write and no done pulse follow.
REQ-025 First start SHALL be accepted on the first rising edge with rst low.

Structure
REQ-026 Package mult_pkg SHALL hold the state type (IDLE, BUSY), data width 32, product width 64, and default MULT_LAT.
REQ-027 SHALL instantiate the existing combinational 32x32 unsigned multiplier mult_32b (ports a, b, prod) once, fed from the latched magnitudes; sign fix-up stays in mult_hilo.

Verification
REQ-028 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> after 4 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle.
REQ-029 Signed -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 Start 2x3, then start 7x7 on the next cycle while busy -> hi=0, lo=6; second request ignored.
REQ-031 Start 10x10, assert rst at cycle 2 -> hi=lo=0, busy=0, no done pulse.
REQ-032 IDLE: mthi with wdata=0x12345678 and mtlo with 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; repeat while busy -> unchanged.
REQ-033 Back-to-back: start 4x4, start 5x5 in the done cycle -> lo=16 then lo=25 MULT_LAT cycles later; 200 random operands checked against a 64-bit reference model.
